// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: sequences ARM LDM/STM block transfers, one register per memory beat.
// Optional macro LDM_PC_LOAD_EN adds the pc_loaded output.
`default_nettype none

module ldm_stm_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic              pre,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        src_reg,
    output logic              wb_en,
    output logic [3:0]        wb_dest,
    output logic [31:0]       wb_value
`ifdef LDM_PC_LOAD_EN
    ,
    output logic              pc_loaded
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_XFER    = 2'd1;
    localparam logic [1:0] S_BASE_WB = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(WORD_BYTES);

    logic [1:0]        r_state;
    logic              r_is_load;
    logic              r_do_wb;
    logic [3:0]        r_base_reg;
    logic [15:0]       r_list;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_final_base;

    logic [4:0]        w_count;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_start_addr;
    logic [ADDR_W-1:0] w_final_base;
    logic [3:0]        w_low;
    logic              w_last;
    logic              w_xfer;

    always_comb begin
        w_count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_count = w_count + 5'(reg_list[i]);
        end
    end

    assign w_span = ADDR_W'(w_count) * C_STEP;

    // Every mode walks upward from the lowest address; only the start point differs.
    always_comb begin
        w_start_addr = base_addr;
        case ({up, pre})
            2'b10:   w_start_addr = base_addr;
            2'b11:   w_start_addr = base_addr + C_STEP;
            2'b00:   w_start_addr = base_addr - w_span + C_STEP;
            default: w_start_addr = base_addr - w_span;
        endcase
    end

    assign w_final_base = up ? (base_addr + w_span) : (base_addr - w_span);

    always_comb begin
        w_low = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) w_low = 4'(i);
        end
    end

    assign w_last = (r_list & (r_list - 16'd1)) == 16'd0;
    assign w_xfer = (r_state == S_XFER);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_load    <= 1'b0;
            r_do_wb      <= 1'b0;
            r_base_reg   <= 4'd0;
            r_list       <= 16'd0;
            r_cur_addr   <= '0;
            r_final_base <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_load    <= is_load;
                        r_base_reg   <= base_reg;
                        r_list       <= reg_list;
                        r_cur_addr   <= w_start_addr;
                        r_final_base <= w_final_base;
                        // A loaded base value takes precedence over the write-back.
                        r_do_wb      <= writeback && !(is_load && reg_list[base_reg]);
                        r_state      <= (w_count == 5'd0) ? S_DONE : S_XFER;
                    end
                end
                S_XFER: begin
                    if (mem_ready) begin
                        r_list     <= r_list & (r_list - 16'd1);
                        r_cur_addr <= r_cur_addr + C_STEP;
                        if (w_last) r_state <= r_do_wb ? S_BASE_WB : S_DONE;
                    end
                end
                S_BASE_WB: r_state <= S_DONE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = w_xfer || (r_state == S_BASE_WB);
    assign done     = (r_state == S_DONE);
    assign mem_req  = w_xfer;
    assign mem_we   = w_xfer && !r_is_load;
    assign mem_addr = w_xfer ? r_cur_addr : '0;
    assign src_reg  = w_xfer ? w_low : 4'd0;

    always_comb begin
        wb_en    = 1'b0;
        wb_dest  = 4'd0;
        wb_value = 32'd0;
        if (w_xfer && r_is_load && mem_ready) begin
            wb_en    = 1'b1;
            wb_dest  = w_low;
            wb_value = mem_rdata;
        end else if (r_state == S_BASE_WB) begin
            wb_en    = 1'b1;
            wb_dest  = r_base_reg;
            wb_value = 32'(r_final_base);
        end
    end

`ifdef LDM_PC_LOAD_EN
    logic r_pc_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_load <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_pc_load <= is_load && reg_list[15];
        end
    end

    assign pc_loaded = done && r_pc_load;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed self-checking bench for ldm_stm_sequencer.
`default_nettype none

module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_load, up, pre, writeback;
    logic [3:0]  base_reg;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  src_reg;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
`ifdef LDM_PC_LOAD_EN
    logic        pc_loaded;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ldm_stm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_load   (is_load),
        .up        (up),
        .pre       (pre),
        .writeback (writeback),
        .base_reg  (base_reg),
        .reg_list  (reg_list),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .src_reg   (src_reg),
        .wb_en     (wb_en),
        .wb_dest   (wb_dest),
        .wb_value  (wb_value)
`ifdef LDM_PC_LOAD_EN
        ,
        .pc_loaded (pc_loaded)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic ld, input logic u, input logic p, input logic w,
                      input logic [3:0] rn, input logic [15:0] lst, input logic [31:0] base);
        is_load = ld; up = u; pre = p; writeback = w;
        base_reg = rn; reg_list = lst; base_addr = base;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] addr, input logic [3:0] src, input logic we,
                        input logic [31:0] rd, input logic ld);
        mem_ready = 1'b1;
        mem_rdata = rd;
        #1;
        check("beat_req", mem_req, 1);
        check("beat_busy", busy, 1);
        check("beat_addr", mem_addr, addr);
        check("beat_src", src_reg, src);
        check("beat_we", mem_we, we);
        check("beat_wb_en", wb_en, ld);
        check("beat_wb_dest", wb_dest, ld ? src : 4'd0);
        check("beat_wb_value", wb_value, ld ? rd : 32'd0);
        step();
        mem_ready = 1'b0;
    endtask

    task automatic base_wb(input logic [3:0] rn, input logic [31:0] val);
        #1;
        check("bwb_en", wb_en, 1);
        check("bwb_dest", wb_dest, rn);
        check("bwb_value", wb_value, val);
        check("bwb_req", mem_req, 0);
        check("bwb_busy", busy, 1);
        step();
    endtask

    task automatic fin(input logic exp_pc);
        #1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_req", mem_req, 0);
        check("done_wb_en", wb_en, 0);
`ifdef LDM_PC_LOAD_EN
        check("pc_loaded", pc_loaded, exp_pc);
`else
        if (exp_pc) begin end
`endif
        step();
        check("done_cleared", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; writeback = 1'b0;
        base_reg = 4'd0; reg_list = 16'd0; base_addr = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wb_en", wb_en, 0);
        rst = 1'b0;

        // LDM IA with base write-back
        go(1, 1, 0, 1, 4'd4, 16'h0006, 32'h100);
        beat(32'h100, 4'd1, 0, 32'hA, 1);
        beat(32'h104, 4'd2, 0, 32'hB, 1);
        base_wb(4'd4, 32'h108);
        fin(0);

        // STM DB with base write-back
        go(0, 0, 1, 1, 4'd13, 16'h4011, 32'h200);
        beat(32'h1F4, 4'd0, 1, 32'h0, 0);
        beat(32'h1F8, 4'd4, 1, 32'h0, 0);
        beat(32'h1FC, 4'd14, 1, 32'h0, 0);
        base_wb(4'd13, 32'h1F4);
        fin(0);

        // LDM DA loading its own base: write-back suppressed
        go(1, 0, 0, 1, 4'd3, 16'h0008, 32'h40);
        beat(32'h40, 4'd3, 0, 32'hDEAD0003, 1);
        fin(0);

        // Empty list: straight to done
        go(1, 1, 0, 1, 4'd2, 16'h0000, 32'h500);
        fin(0);

        // Stall on the second beat while start and inputs are wiggled
        go(1, 1, 0, 0, 4'd5, 16'h0003, 32'h300);
        beat(32'h300, 4'd0, 0, 32'h11, 1);
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b0;
            start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h0;
            #1;
            check("stall_addr", mem_addr, 32'h304);
            check("stall_src", src_reg, 4'd1);
            check("stall_req", mem_req, 1);
            check("stall_wb_en", wb_en, 0);
            step();
        end
        start = 1'b0;
        beat(32'h304, 4'd1, 0, 32'h22, 1);
        fin(0);

        // Reset in the middle of an STM
        go(0, 1, 0, 1, 4'd2, 16'h00FF, 32'h600);
        beat(32'h600, 4'd0, 1, 32'h0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_src", src_reg, 0);
        check("mid_rst_wb_en", wb_en, 0);
        check("mid_rst_wb_dest", wb_dest, 0);
        check("mid_rst_wb_value", wb_value, 0);
        check("mid_rst_done", done, 0);

        // Fresh LDM IB of r15 after reset
        go(1, 1, 1, 0, 4'd0, 16'h8000, 32'h1000);
        beat(32'h1004, 4'd15, 0, 32'hCAFE, 1);
        fin(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
